// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear coordinate generator.
package bilinear_pkg;

    localparam int FRAC_W = 8;

    // Q24.8 source-position accumulator
    typedef logic [31:0] coord_q24_8_t;

    // Q8.8 per-pixel / per-row source step
    typedef logic [15:0] step_q8_8_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } coord_gen_state_t;

endpackage

// File: rtl/coord_axis_clamp.sv
// Splits one Q24.8 accumulator into integer base and Q0.8 fraction.
// Positions at or past the last source pixel are pinned to DIM-2 with a
// full fraction so that base+1 always stays inside the image.
module coord_axis_clamp
    import bilinear_pkg::*;
#(
    parameter int DIM = 16
) (
    input  coord_q24_8_t      i_acc,
    output logic [15:0]       o_int,
    output logic [FRAC_W-1:0] o_frac
);

    localparam logic [23:0] LIMIT    = 24'(DIM - 1);
    localparam logic [15:0] MAX_BASE = 16'(DIM - 2);

    // Clamp the integer part and split out the fraction
    always_comb begin
        o_int  = i_acc[FRAC_W+15:FRAC_W];
        o_frac = i_acc[FRAC_W-1:0];
        if (i_acc[31:FRAC_W] >= LIMIT) begin
            o_int  = MAX_BASE;
            o_frac = '1;
        end
    end

endmodule

// File: rtl/bilinear_coord_gen.sv
// Row-major output-pixel walker producing source coordinates and fractional
// weights for the bilinear datapath, one request per cycle under no stall.
//
// Request handshake: o_req_valid rises with a complete request and stays high
// with every o_req_* field frozen until i_req_ready is sampled high on a clock
// edge; that edge is the transfer, and the next request (if any) is presented
// immediately after it with no bubble.
module bilinear_coord_gen
    import bilinear_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [15:0]      i_out_width,
    input  logic [15:0]      i_out_height,
    input  step_q8_8_t       i_step_x,
    input  step_q8_8_t       i_step_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_req_valid,
    input  logic             i_req_ready,
    output logic [15:0]      o_req_xi_base,
    output logic [15:0]      o_req_yi_base,
    output logic [7:0]       o_req_fx_q,
    output logic [7:0]       o_req_fy_q,
    output logic [15:0]      o_req_out_x,
    output logic [15:0]      o_req_out_y,
    output logic             o_req_last,
    output coord_gen_state_t o_dbg_state
);

    coord_gen_state_t r_state;
    coord_gen_state_t w_next_state;

    logic [15:0]  r_width;
    logic [15:0]  r_height;
    step_q8_8_t   r_step_x;
    step_q8_8_t   r_step_y;
    logic [15:0]  r_ox;
    logic [15:0]  r_oy;
    coord_q24_8_t r_acc_x;
    coord_q24_8_t r_acc_y;

    logic w_load_cfg;
    logic w_first;
    logic w_step;
    logic w_valid;
    logic w_row_end;
    logic w_last;
    logic w_handshake;

    assign w_valid     = (r_state == ISSUE);
    assign w_row_end   = (r_ox == r_width - 16'd1);
    assign w_last      = w_row_end && (r_oy == r_height - 16'd1);
    assign w_handshake = w_valid && i_req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and datapath control; abort outranks a coincident handshake
    always_comb begin
        w_next_state = r_state;
        w_load_cfg   = 1'b0;
        w_first      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load_cfg = 1'b1;
                    if (i_out_width == 16'd0 || i_out_height == 16'd0) begin
                        w_next_state = FINISH;
                    end else begin
                        w_next_state = ISSUE;
                        w_first      = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (i_abort) begin
                    w_next_state = IDLE;
                end else if (w_handshake) begin
                    if (w_last) w_next_state = FINISH;
                    else        w_step       = 1'b1;
                end
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Config latch, output-pixel counters and Q24.8 accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width  <= '0;
            r_height <= '0;
            r_step_x <= '0;
            r_step_y <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_acc_x  <= '0;
            r_acc_y  <= '0;
        end else begin
            if (w_load_cfg) begin
                r_width  <= i_out_width;
                r_height <= i_out_height;
                r_step_x <= i_step_x;
                r_step_y <= i_step_y;
            end
            if (w_first) begin
                r_ox    <= '0;
                r_oy    <= '0;
                r_acc_x <= '0;
                r_acc_y <= '0;
            end else if (w_step) begin
                if (w_row_end) begin
                    r_ox    <= '0;
                    r_oy    <= r_oy + 16'd1;
                    r_acc_x <= '0;
                    r_acc_y <= r_acc_y + {16'd0, r_step_y};
                end else begin
                    r_ox    <= r_ox + 16'd1;
                    r_acc_x <= r_acc_x + {16'd0, r_step_x};
                end
            end
        end
    end

    coord_axis_clamp #(.DIM(IMG_WIDTH)) u_clamp_x (
        .i_acc  (r_acc_x),
        .o_int  (o_req_xi_base),
        .o_frac (o_req_fx_q)
    );

    coord_axis_clamp #(.DIM(IMG_HEIGHT)) u_clamp_y (
        .i_acc  (r_acc_y),
        .o_int  (o_req_yi_base),
        .o_frac (o_req_fy_q)
    );

    assign o_req_valid = w_valid;
    assign o_req_last  = w_valid && w_last;
    assign o_req_out_x = r_ox;
    assign o_req_out_y = r_oy;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == FINISH);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Scoreboard bench for bilinear_coord_gen: random and directed frames, with
// expected requests computed from absolute positions (ox*step, oy*step).
module tb_bilinear_coord_gen;
    import bilinear_pkg::*;

    localparam int IW = 16;
    localparam int IH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [15:0]      i_out_width = '0;
    logic [15:0]      i_out_height = '0;
    logic [15:0]      i_step_x = '0;
    logic [15:0]      i_step_y = '0;
    logic             i_req_ready = 1'b1;
    logic             o_busy, o_done, o_req_valid, o_req_last;
    logic [15:0]      o_req_xi_base, o_req_yi_base, o_req_out_x, o_req_out_y;
    logic [7:0]       o_req_fx_q, o_req_fy_q;
    coord_gen_state_t o_dbg_state;

    bilinear_coord_gen #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_out_width   (i_out_width),
        .i_out_height  (i_out_height),
        .i_step_x      (i_step_x),
        .i_step_y      (i_step_y),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_req_valid   (o_req_valid),
        .i_req_ready   (i_req_ready),
        .o_req_xi_base (o_req_xi_base),
        .o_req_yi_base (o_req_yi_base),
        .o_req_fx_q    (o_req_fx_q),
        .o_req_fy_q    (o_req_fy_q),
        .o_req_out_x   (o_req_out_x),
        .o_req_out_y   (o_req_out_y),
        .o_req_last    (o_req_last),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [80:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0, done_cyc = -1, busy_cnt = 0;
    int hs_cnt = 0, last_hs_cyc = -1, last_cnt = 0, stall_cnt = 0;
    int start_cyc = 0;
    bit rand_ready = 1'b0;
    int hold_cnt = 0;
    bit prev_stall = 1'b0;
    logic [80:0] prev_vec = '0;

    task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: absolute source position of pixel (ox,oy), clamped so that
    // the right/bottom neighbour is still inside the source image.
    function automatic logic [80:0] model_req(input int w, input int h, input int sx,
                                              input int sy, input int ox, input int oy);
        longint ax, ay;
        int xi, yi, fx, fy;
        bit last;
        ax = longint'(ox) * sx;
        ay = longint'(oy) * sy;
        if (ax / 256 >= IW - 1) begin xi = IW - 2; fx = 255; end
        else begin xi = int'(ax / 256); fx = int'(ax % 256); end
        if (ay / 256 >= IH - 1) begin yi = IH - 2; fy = 255; end
        else begin yi = int'(ay / 256); fy = int'(ay % 256); end
        last = (ox == w - 1) && (oy == h - 1);
        return {16'(xi), 16'(yi), 8'(fx), 8'(fy), 16'(ox), 16'(oy), last};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input int sx, input int sy);
        for (int oy = 0; oy < h; oy++)
            for (int ox = 0; ox < w; ox++)
                exp_q.push_back(model_req(w, h, sx, sy, ox, oy));
        i_out_width  = 16'(w);
        i_out_height = 16'(h);
        i_step_x     = 16'(sx);
        i_step_y     = 16'(sy);
        i_start      = 1'b1;
        start_cyc    = cyc;
        tick();
        i_start      = 1'b0;
        i_out_width  = 16'($urandom);
        i_out_height = 16'($urandom);
        i_step_x     = 16'($urandom);
        i_step_y     = 16'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        check("done_count", 81'(done_cnt - d0), 81'd1);
        check("queue_drained", 81'(exp_q.size()), 81'd0);
    endtask

    task automatic run_frame(input int w, input int h, input int sx, input int sy, input int budget);
        int d0;
        d0 = done_cnt;
        start_frame(w, h, sx, sy);
        wait_done(d0, budget);
    endtask

    // Ready driver: random or always-high, with an optional forced stall
    always @(posedge clk) begin
        #2;
        if (hold_cnt > 0) begin
            i_req_ready = 1'b0;
            hold_cnt--;
        end else begin
            i_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [80:0] act;
        act = {o_req_xi_base, o_req_yi_base, o_req_fx_q, o_req_fy_q,
               o_req_out_x, o_req_out_y, o_req_last};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_busy) busy_cnt++;
            if (prev_stall) begin
                check("valid_held", 81'(o_req_valid), 81'd1);
                if (o_req_valid) check("req_held_stable", act, prev_vec);
            end
            if (o_req_valid && i_req_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got %h expected none (cycle %0d)", act, cyc);
                end else begin
                    check("req", act, exp_q.pop_front());
                end
                hs_cnt++;
                last_hs_cyc = cyc;
                if (o_req_last) last_cnt++;
            end
            if (o_req_valid && !i_req_ready) stall_cnt++;
            prev_stall = o_req_valid && !i_req_ready;
            prev_vec   = act;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0, hs0, s0, b0, lc0, n;

        repeat (3) tick();
        check("rst_valid", 81'(o_req_valid), 81'd0);
        check("rst_busy", 81'(o_busy), 81'd0);
        check("rst_done", 81'(o_done), 81'd0);
        check("rst_last", 81'(o_req_last), 81'd0);
        check("rst_data", {o_req_xi_base, o_req_yi_base, o_req_fx_q, o_req_fy_q,
                           o_req_out_x, o_req_out_y}, 81'd0);
        rst_n = 1'b1;
        tick();

        // 32x32 frame at half-pixel steps, no backpressure
        d0 = done_cnt; hs0 = hs_cnt; lc0 = last_cnt;
        check("idle_valid", 81'(o_req_valid), 81'd0);
        start_frame(32, 32, 16'h0080, 16'h0080);
        check("valid_after_start", 81'(o_req_valid), 81'd1);
        check("busy_after_start", 81'(o_busy), 81'd1);
        wait_done(d0, 1300);
        check("hs_total", 81'(hs_cnt - hs0), 81'd1024);
        check("hs_back_to_back", 81'(last_hs_cyc - (start_cyc + 1)), 81'd1023);
        check("last_once", 81'(last_cnt - lc0), 81'd1);
        check("done_after_last", 81'(done_cyc - last_hs_cyc), 81'd1);
        check("idle_busy", 81'(o_busy), 81'd0);

        // Three-cycle stall on ox=5
        d0 = done_cnt; s0 = stall_cnt;
        start_frame(32, 2, 16'h0080, 16'h0080);
        n = 0;
        while (!(o_req_valid && o_req_out_x == 16'd5 && o_req_out_y == 16'd0) && n < 100) begin
            tick();
            n++;
        end
        check("reach_ox5", 81'(n < 100), 81'd1);
        hold_cnt = 3;
        wait_done(d0, 200);
        check("stall_cycles", 81'(stall_cnt - s0), 81'd3);

        // Empty frames: start is sampled at the end of its cycle, FINISH follows
        d0 = done_cnt; b0 = busy_cnt; hs0 = hs_cnt;
        start_frame(0, 5, 16'h0100, 16'h0100);
        repeat (5) tick();
        check("w0_done_count", 81'(done_cnt - d0), 81'd1);
        check("w0_done_cycle", 81'(done_cyc - start_cyc), 81'd1);
        check("w0_busy_cycles", 81'(busy_cnt - b0), 81'd1);
        check("w0_no_req", 81'(hs_cnt - hs0), 81'd0);
        d0 = done_cnt;
        start_frame(7, 0, 16'h0100, 16'h0100);
        repeat (5) tick();
        check("h0_done_count", 81'(done_cnt - d0), 81'd1);

        // Abort on request 100 (ox=4, oy=3) with ready high
        d0 = done_cnt; hs0 = hs_cnt;
        start_frame(32, 32, 16'h0080, 16'h0080);
        n = 0;
        while (!(o_req_valid && o_req_out_x == 16'd4 && o_req_out_y == 16'd3) && n < 300) begin
            tick();
            n++;
        end
        check("reach_req100", 81'(n < 300), 81'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_valid", 81'(o_req_valid), 81'd0);
        check("abort_busy", 81'(o_busy), 81'd0);
        repeat (4) tick();
        check("abort_no_done", 81'(done_cnt - d0), 81'd0);
        check("abort_hs_count", 81'(hs_cnt - hs0), 81'd101);
        exp_q.delete();
        run_frame(4, 3, 16'h0080, 16'h0080, 100);

        // Randomized frames with random backpressure, plus 1x1 boundary
        rand_ready = 1'b1;
        run_frame(1, 1, 16'h0123, 16'h0456, 50);
        for (int k = 0; k < 8; k++) begin
            run_frame($urandom_range(1, 9), $urandom_range(1, 5),
                      $urandom_range(0, 16'h0400), $urandom_range(0, 16'h0400), 600);
        end
        run_frame(6, 4, 16'hFFFF, 16'h1000, 200);
        rand_ready = 1'b0;

        // Asynchronous reset mid-frame, then integer stepping
        d0 = done_cnt;
        start_frame(16, 4, 16'h0100, 16'h0100);
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 81'(o_req_valid), 81'd0);
        check("arst_busy", 81'(o_busy), 81'd0);
        check("arst_xi", 81'(o_req_xi_base), 81'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_no_done", 81'(done_cnt - d0), 81'd0);
        run_frame(20, 2, 16'h0100, 16'h0100, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
